bank_context_stack: RTL and testbench
=====================================

# bank_context_stack

Parametrised successor to the memory bank selector: holds the active memory bank number and adds a LIFO of saved bank contexts. A call or interrupt entry can switch banks and later restore the previous one in a single cycle. The block sits between the control unit and the memory address path. `out_data` drives the bank bits of every memory access; the control unit drives the command strobes.

## Interface
- `BANK_W`, default 2: width of a bank number.
- `DEPTH`, default 4: number of saved contexts; must be ≥ 1.
- `RESET_BANK`, default 0: bank selected after reset; must be < 2^BANK_W.
- `LVL_W`, derived as `$clog2(DEPTH+1)`: width of `level`. Not overridable.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write_en`  in  1  load `in_data` as the active bank.
- `push_en`  in  1  save the active bank onto the stack.
- `pop_en`  in  1  restore the active bank from the top of the stack.
- `inc_en`  in  1  advance the active bank by one, modulo 2^BANK_W.
- `err_clr`  in  1  clear the sticky error flag.
- `in_data`  in  BANK_W  new bank number.
- `out_data`  out  BANK_W  active bank, registered.
- `level`  out  LVL_W  number of saved contexts, 0..DEPTH.
- `empty`  out  1  `level == 0`.
- `full`  out  1  `level == DEPTH`.
- `err`  out  1  sticky overflow/underflow/illegal-command flag.

## Operation
Commands are sampled on the rising edge of `clk`. Exactly one action is taken per cycle, chosen in this priority order:

1. `push_en & pop_en`: illegal. No state change; `err` is set.
2. `pop_en`:
   - not empty: `out_data` ← top entry, `level` − 1.
   - empty: underflow. No change; `err` is set.
   - `write_en` and `inc_en` are ignored in this cycle.
3. `push_en`:
   - not full: top entry ← current `out_data`, `level` + 1. `out_data` ← `in_data` if `write_en`, otherwise it is unchanged (call-with-switch). `inc_en` is ignored.
   - full: overflow. No change at all, including no write; `err` is set.
4. `write_en`: `out_data` ← `in_data`.
5. `inc_en`: `out_data` ← `out_data + 1`, truncated to BANK_W bits. The maximum bank wraps to 0.
6. No strobe: hold.

Error flag rules:
- `err` is sticky and is cleared only by `err_clr` or reset.
- If `err_clr` arrives in the same cycle as a new error, the new error wins and `err` stays 1.
- Popped entries are not cleared. Storage contents above `level` are don't-care and must never be observable.
- `empty`, `full` and `level` are consistent with each other in every cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - `out_data` = RESET_BANK, `level` = 0, `empty` = 1, `full` = 0, `err` = 0.
  - Stack storage is not reset.
  - Reset mid-sequence discards all saved contexts.
- Latency is one cycle. A command sampled at edge N is visible on all outputs after edge N and stable for the whole of cycle N+1.
- There is no combinational path from any input to any output.
- Back-to-back push/pop on consecutive cycles is fully supported at one operation per cycle.
- With DEPTH=1, `full` and `empty` are mutually exclusive. `level` is 1 bit wide.
- `in_data` is only sampled when `write_en` is high. X on `in_data` otherwise must not propagate.

## Structure
- Shared package/include `bank_pkg`:
  - the command-priority encoding (internal op enum: NOP, WRITE, INC, PUSH, POP, ILLEGAL);
  - the reset-bank default.
- Sub-module `bank_lifo`, parametrised by `BANK_W` and `DEPTH`:
  - holds the storage array, the level counter and the full/empty flags;
  - `push`/`pop` inputs that are already qualified by the parent;
  - a `top` output.
- The parent keeps the active-bank register, the command decoder and the error flag.

## Test plan
- Reset values, BANK_W=2, DEPTH=4, RESET_BANK=1: assert `rst_n` low mid-cycle. Outputs become `out_data`=1, `level`=0, `empty`=1, `err`=0 immediately, without waiting for a clock edge.
- Write and increment: write 2 → `out_data`=2. inc → 3. inc → 0 (wrap). Hold cycle → 0.
- Call/return nesting, starting from bank 0:
  - push+write 1, then push+write 2, then push+write 3 → `out_data`=3, `level`=3;
  - pop, pop, pop → `out_data` = 2, 1, 0 in turn, `level`=0, `empty`=1.
- Overflow: push 4 times → `full`=1. A 5th push with write_en and in_data=2 → `out_data` unchanged, `level`=4, `err`=1. `err_clr` → `err`=0.
- Underflow and illegal command:
  - pop when empty → `err`=1, `out_data` unchanged;
  - clear; push&pop together → `err`=1, `level` unchanged;
  - `err_clr` in the same cycle as an underflow → `err` remains 1.
- Reset mid-stack: with `level`=2, assert `rst_n` → `level`=0, `out_data`=RESET_BANK. A following pop flags underflow.

Source files
------------

// File: rtl/bank_context_stack_pkg.sv
// Shared definitions for the bank context stack: command-priority decode and reset default.
package bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_WRITE,
        OP_INC,
        OP_PUSH,
        OP_POP,
        OP_ILLEGAL
    } op_e;

    localparam int RESET_BANK_DEF = 0;

    // One action per cycle; the earlier test wins when several strobes are high.
    function automatic op_e decode_op(input logic write_en, input logic push_en,
                                      input logic pop_en, input logic inc_en);
        if (push_en && pop_en) return OP_ILLEGAL;
        if (pop_en)            return OP_POP;
        if (push_en)           return OP_PUSH;
        if (write_en)          return OP_WRITE;
        if (inc_en)            return OP_INC;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/bank_context_stack_if.sv
// Control-unit side of the bank context stack: command strobes in, bank/stack status out.
interface bank_context_stack_if #(
    parameter int BANK_W = 2,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              write_en;
    logic              push_en;
    logic              pop_en;
    logic              inc_en;
    logic              err_clr;
    logic [BANK_W-1:0] in_data;
    logic [BANK_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              err;

    modport master (
        output write_en, push_en, pop_en, inc_en, err_clr, in_data,
        input  out_data, level, empty, full, err
    );

    modport slave (
        input  write_en, push_en, pop_en, inc_en, err_clr, in_data,
        output out_data, level, empty, full, err
    );
endinterface

// File: rtl/bank_context_stack_lifo.sv
// Saved-context LIFO: storage, level counter and full/empty flags. push/pop arrive pre-qualified.
module bank_lifo #(
    parameter  int BANK_W = 2,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BANK_W-1:0] din,
    output logic [BANK_W-1:0] top,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full
);
    logic [BANK_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]  lvl_q;

    // Storage is deliberately not reset; entries at or above level are never read out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (push && lvl_q == LVL_W'(i)) mem[i] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lvl_q <= '0;
        else if (push) lvl_q <= lvl_q + LVL_W'(1);
        else if (pop)  lvl_q <= lvl_q - LVL_W'(1);
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (lvl_q == LVL_W'(i + 1)) top = mem[i];
    end

    assign level = lvl_q;
    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == LVL_W'(DEPTH));
endmodule

// File: rtl/bank_context_stack.sv
// Active memory bank register with a LIFO of saved bank contexts for call/interrupt nesting.
module bank_context_stack
    import bank_pkg::*;
#(
    parameter int BANK_W     = 2,
    parameter int DEPTH      = 4,
    parameter int RESET_BANK = RESET_BANK_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_context_stack_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    op_e               op;
    logic              lifo_push, lifo_pop, err_set;
    logic [BANK_W-1:0] bank_q, bank_d, top;
    logic [LVL_W-1:0]  level;
    logic              empty, full;
    logic              err_q;

    always_comb begin
        op        = decode_op(bus.write_en, bus.push_en, bus.pop_en, bus.inc_en);
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        err_set   = 1'b0;
        bank_d    = bank_q;
        unique case (op)
            OP_ILLEGAL: err_set = 1'b1;
            OP_POP: begin
                if (empty) err_set = 1'b1;
                else begin
                    lifo_pop = 1'b1;
                    bank_d   = top;
                end
            end
            // A full stack blocks the whole call, including its bank switch.
            OP_PUSH: begin
                if (full) err_set = 1'b1;
                else begin
                    lifo_push = 1'b1;
                    if (bus.write_en) bank_d = bus.in_data;
                end
            end
            OP_WRITE: bank_d = bus.in_data;
            OP_INC:   bank_d = bank_q + BANK_W'(1);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= BANK_W'(RESET_BANK);
            err_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            if (err_set)          err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    bank_lifo #(.BANK_W(BANK_W), .DEPTH(DEPTH)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .din   (bank_q),
        .top   (top),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    assign bus.out_data = bank_q;
    assign bus.level    = level;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_bank_context_stack.sv
// Bench for bank_context_stack: directed scenarios plus random commands against a queue-based model.
module tb_bank_context_stack;
    localparam int BANK_W     = 2;
    localparam int DEPTH      = 4;
    localparam int RESET_BANK = 1;
    localparam int LVL_W      = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bank_context_stack_if #(.BANK_W(BANK_W), .DEPTH(DEPTH)) bus();

    bank_context_stack #(.BANK_W(BANK_W), .DEPTH(DEPTH), .RESET_BANK(RESET_BANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: active bank, saved contexts as a queue, sticky error bit.
    int m_bank;
    int m_stk[$];
    bit m_err;

    task automatic model_reset();
        m_bank = RESET_BANK;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit e;
        e = 1'b0;
        if (bus.push_en && bus.pop_en) e = 1'b1;
        else if (bus.pop_en) begin
            if (m_stk.size() == 0) e = 1'b1;
            else m_bank = m_stk.pop_back();
        end else if (bus.push_en) begin
            if (m_stk.size() == DEPTH) e = 1'b1;
            else begin
                m_stk.push_back(m_bank);
                if (bus.write_en) m_bank = int'(bus.in_data);
            end
        end else if (bus.write_en) m_bank = int'(bus.in_data);
        else if (bus.inc_en) m_bank = (m_bank + 1) % (1 << BANK_W);
        if (e) m_err = 1'b1;
        else if (bus.err_clr) m_err = 1'b0;
    endtask

    task automatic drive(input bit w, input bit p, input bit po, input bit i, input bit c, input int d);
        bus.write_en = w;
        bus.push_en  = p;
        bus.pop_en   = po;
        bus.inc_en   = i;
        bus.err_clr  = c;
        bus.in_data  = BANK_W'(d);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 3); tick();
        drive(0, 0, 1, 0, 0, 0); tick();   // underflow so err is set before reset
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL pre_reset_err: got %0b expected 1", bus.err); end
        drive(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_data !== 2'd1) begin failures++; $display("FAIL reset_out: got %0d expected 1", bus.out_data); end
        checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1/0", bus.empty, bus.full); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", bus.err); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_inc();
        int exp_seq[4] = '{2, 3, 0, 0};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(1, 0, 0, 0, 0, 2);
                1, 2: drive(0, 0, 0, 1, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0);
            endcase
            tick();
            checks++; if (bus.out_data !== BANK_W'(exp_seq[k])) begin failures++; $display("FAIL write_inc_%0d: got %0d expected %0d", k, bus.out_data, exp_seq[k]); end
        end
    endtask

    task automatic test_nesting();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 0, 0, 0, k); tick();
        end
        checks++; if (bus.out_data !== 2'd3 || bus.level !== 3'd3) begin failures++; $display("FAIL nest_push: got out=%0d lvl=%0d expected 3/3", bus.out_data, bus.level); end
        for (int k = 2; k >= 0; k--) begin
            drive(0, 0, 1, 0, 0, 0); tick();
            checks++; if (bus.out_data !== BANK_W'(k)) begin failures++; $display("FAIL nest_pop: got %0d expected %0d", bus.out_data, k); end
        end
        checks++; if (bus.level !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL nest_empty: got lvl=%0d empty=%0b expected 0/1", bus.level, bus.empty); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0, 0); tick();
        end
        checks++; if (bus.full !== 1'b1 || bus.level !== 3'd4 || bus.empty !== 1'b0) begin failures++; $display("FAIL ovf_full: got full=%0b lvl=%0d expected 1/4", bus.full, bus.level); end
        drive(1, 1, 0, 0, 0, 2); tick();
        checks++; if (bus.out_data !== 2'd0 || bus.level !== 3'd4) begin failures++; $display("FAIL ovf_hold: got out=%0d lvl=%0d expected 0/4", bus.out_data, bus.level); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %0b expected 1", bus.err); end
        drive(0, 0, 0, 0, 1, 0); tick();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %0b expected 0", bus.err); end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 0, 0); tick();
        end
        checks++; if (bus.empty !== 1'b1 || bus.out_data !== 2'd0) begin failures++; $display("FAIL ovf_drain: got empty=%0b out=%0d expected 1/0", bus.empty, bus.out_data); end
    endtask

    task automatic test_underflow_illegal();
        drive(0, 0, 1, 0, 0, 0); tick();
        checks++; if (bus.err !== 1'b1 || bus.out_data !== 2'd0) begin failures++; $display("FAIL udf: got err=%0b out=%0d expected 1/0", bus.err, bus.out_data); end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 1); tick();
        checks++; if (bus.err !== 1'b0 || bus.level !== 3'd1) begin failures++; $display("FAIL udf_setup: got err=%0b lvl=%0d expected 0/1", bus.err, bus.level); end
        drive(1, 1, 1, 1, 0, 3); tick();
        checks++; if (bus.err !== 1'b1 || bus.level !== 3'd1 || bus.out_data !== 2'd1) begin failures++; $display("FAIL illegal: got err=%0b lvl=%0d out=%0d expected 1/1/1", bus.err, bus.level, bus.out_data); end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        checks++; if (bus.err !== 1'b0 || bus.out_data !== 2'd0 || bus.level !== 3'd0) begin failures++; $display("FAIL udf_pop: got err=%0b out=%0d lvl=%0d expected 0/0/0", bus.err, bus.out_data, bus.level); end
        drive(0, 0, 1, 0, 1, 0); tick();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_clr_race: got %0b expected 1", bus.err); end
        drive(0, 0, 0, 0, 1, 0); tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 0, 0, 2); tick();
        drive(1, 1, 0, 0, 0, 3); tick();
        checks++; if (bus.level !== 3'd2 || bus.out_data !== 2'd3) begin failures++; $display("FAIL mid_setup: got lvl=%0d out=%0d expected 2/3", bus.level, bus.out_data); end
        drive(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.level !== 3'd0 || bus.out_data !== 2'd1) begin failures++; $display("FAIL mid_reset: got lvl=%0d out=%0d expected 0/1", bus.level, bus.out_data); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 0, 0); tick();
        checks++; if (bus.err !== 1'b1 || bus.level !== 3'd0 || bus.out_data !== 2'd1) begin failures++; $display("FAIL mid_udf: got err=%0b lvl=%0d out=%0d expected 1/0/1", bus.err, bus.level, bus.out_data); end
        drive(0, 0, 0, 0, 1, 0); tick();
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            drive(($urandom % 3) == 0, r < 30, (r >= 25) && (r < 55), ($urandom % 3) == 0,
                  ($urandom % 8) == 0, $urandom_range(0, (1 << BANK_W) - 1));
            tick();
            checks++;
            if (bus.out_data !== BANK_W'(m_bank) || bus.level !== LVL_W'(m_stk.size()) ||
                bus.empty !== (m_stk.size() == 0) || bus.full !== (m_stk.size() == DEPTH) ||
                bus.err !== m_err) begin
                failures++;
                $display("FAIL rand_%0d: got out=%0d lvl=%0d e=%0b f=%0b err=%0b expected out=%0d lvl=%0d err=%0b",
                         k, bus.out_data, bus.level, bus.empty, bus.full, bus.err, m_bank, m_stk.size(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_inc();
        test_nesting();
        test_overflow();
        test_underflow_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
